imem_arbiter: RTL

Sequencing arbiter that shares the single-port main instruction/data memory between the instruction cache refill path and the data-side access port. It serialises requests with round-robin arbitration. An instruction miss is turned into an aligned `BLOCK_SIZE`-word burst assembled into one cache line, and a data request is turned into a single-word read or write. It sits between `inst_cache`/data port and the memory model, replacing the direct combinational block fetch.

---
 rtl/imem_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Shares the single-port main memory between I-cache line refills and single-word data accesses.
// Latency: zero-wait memory gives ic_done BLOCK_SIZE+1 cycles and dc_done 2 cycles after the request is sampled.
// Backpressure: mem_ready=0 stretches the current beat with address and data held; requests stay pending until granted.
//
// Ports:
//   clk, reset                     - rising-edge clock, asynchronous active-high reset
//   ic_req/ic_addr -> ic_data/ic_done
//                                  - refill request (level) and assembled line with done pulse
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_rdata/dc_done
//                                  - data request (level) and read data with done pulse
//   mem_valid/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready
//                                  - one beat at a time to the memory
//   busy, owner                    - not idle; current or last grant (0 = I-cache, 1 = data)
module imem_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ic_req,
  input  logic [WORD_SIZE-1:0]            ic_addr,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] ic_data,
  output logic                            ic_done,
  input  logic                            dc_req,
  input  logic                            dc_we,
  input  logic [WORD_SIZE-1:0]            dc_addr,
  input  logic [WORD_SIZE-1:0]            dc_wdata,
  output logic [WORD_SIZE-1:0]            dc_rdata,
  output logic                            dc_done,
  output logic                            mem_valid,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [WORD_SIZE-1:0]            mem_rdata,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic                            owner
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IC_BURST  = 2'd1,
    DC_ACCESS = 2'd2
  } state_t;

  // Data request captured at grant time; the port inputs are free to change afterwards.
  typedef struct packed {
    logic                 we;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } dreq_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 last_owner;
  logic [WORD_SIZE-1:0] base;
  dreq_t                dreq;

  logic ic_cand;
  logic dc_cand;
  logic grant_ic;
  logic grant_dc;
  logic beat_last;

  // A requester whose done pulse is showing is still holding its old request; ignore it for that cycle.
  assign ic_cand = ic_req & ~ic_done;
  assign dc_cand = dc_req & ~dc_done;

  // On a tie the side that did not win last time goes next.
  assign grant_ic = ic_cand & (~dc_cand | last_owner);
  assign grant_dc = dc_cand & (~ic_cand | ~last_owner);

  assign beat_last = (cnt == CNT_W'(BLOCK_SIZE - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_ic) begin
          state_nxt = IC_BURST;
        end else if (grant_dc) begin
          state_nxt = DC_ACCESS;
        end
      end
      IC_BURST: begin
        if (mem_ready && beat_last) begin
          state_nxt = IDLE;
        end
      end
      DC_ACCESS: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-side outputs, purely from state and latched registers
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IC_BURST: begin
        mem_valid = 1'b1;
        // base is line aligned, so this add never carries out of the line.
        mem_addr  = base + WORD_SIZE'(cnt);
      end
      DC_ACCESS: begin
        mem_valid = 1'b1;
        mem_we    = dreq.we;
        mem_addr  = dreq.addr;
        mem_wdata = dreq.wdata;
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign owner = last_owner;

  // ---------------------------------------------------------------------------
  // Grant capture, beat counting, result registers and done pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      last_owner <= 1'b1;
      base       <= '0;
      dreq       <= '0;
      ic_data    <= '0;
      dc_rdata   <= '0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic) begin
            last_owner <= 1'b0;
            base       <= ic_addr & ~WORD_SIZE'(BLOCK_SIZE - 1);
            cnt        <= '0;
          end else if (grant_dc) begin
            last_owner <= 1'b1;
            dreq.we    <= dc_we;
            dreq.addr  <= dc_addr;
            dreq.wdata <= dc_wdata;
          end
        end
        IC_BURST: begin
          if (mem_ready) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
              if (cnt == CNT_W'(k)) begin
                ic_data[k*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
              end
            end
            cnt <= cnt + 1'b1;
            if (beat_last) begin
              ic_done <= 1'b1;
            end
          end
        end
        DC_ACCESS: begin
          if (mem_ready) begin
            // A write leaves the last read value in place.
            if (!dreq.we) begin
              dc_rdata <= mem_rdata;
            end
            dc_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
